// File: rtl/demux1_8_seq.sv
// rtl/demux1_8_seq.sv - 1:8 registered demultiplexer with addressed and round-robin routing
// Tracks per-channel unread data, sticky overrun flags and a frame-complete pulse.
module demux1_8_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic [2:0]       select,
  input  logic             valid_in,
  input  logic             mode,
  input  logic             sync,
  input  logic             clear,
  input  logic [7:0]       rd_ack,
  output logic [WIDTH-1:0] dataout_0,
  output logic [WIDTH-1:0] dataout_1,
  output logic [WIDTH-1:0] dataout_2,
  output logic [WIDTH-1:0] dataout_3,
  output logic [WIDTH-1:0] dataout_4,
  output logic [WIDTH-1:0] dataout_5,
  output logic [WIDTH-1:0] dataout_6,
  output logic [WIDTH-1:0] dataout_7,
  output logic [7:0]       out_valid,
  output logic [7:0]       overrun,
  output logic [2:0]       cur_ch,
  output logic             frame_done
);

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             fd_q, fd_d;
  logic [2:0]       tgt;

  // sync in round-robin mode steers the write to channel 0 regardless of the pointer
  always_comb begin
    if (mode) begin
      tgt = sync ? 3'd0 : ptr_q;
    end else begin
      tgt = select;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~rd_ack;
    ovr_d   = ovr_q;
    ptr_d   = ptr_q;
    fd_d    = 1'b0;
    if (clear) begin
      valid_d = '0;
      ovr_d   = '0;
      ptr_d   = '0;
    end else begin
      if (valid_in) begin
        data_d[tgt]  = datain;
        valid_d[tgt] = 1'b1;
        // a same-cycle ack means the old word was consumed, so it is not an overrun
        if (valid_q[tgt] && !rd_ack[tgt]) begin
          ovr_d[tgt] = 1'b1;
        end
      end
      if (mode) begin
        if (valid_in) begin
          ptr_d = tgt + 3'd1;
        end else if (sync) begin
          ptr_d = 3'd0;
        end
        fd_d = valid_in && (tgt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      ovr_q   <= '0;
      ptr_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
      fd_q    <= fd_d;
    end
  end

  assign dataout_0  = data_q[0];
  assign dataout_1  = data_q[1];
  assign dataout_2  = data_q[2];
  assign dataout_3  = data_q[3];
  assign dataout_4  = data_q[4];
  assign dataout_5  = data_q[5];
  assign dataout_6  = data_q[6];
  assign dataout_7  = data_q[7];
  assign out_valid  = valid_q;
  assign overrun    = ovr_q;
  assign cur_ch     = ptr_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_demux1_8_seq.sv
// tb/tb_demux1_8_seq.sv - self-checking bench for demux1_8_seq
// Reference model tracks channel contents; compared against the DUT every falling edge.
module tb_demux1_8_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] datain = '0;
  logic [2:0]   select = '0;
  logic         valid_in = 1'b0;
  logic         mode = 1'b0;
  logic         sync = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   rd_ack = '0;
  logic [W-1:0] dout [8];
  logic [7:0]   out_valid, overrun;
  logic [2:0]   cur_ch;
  logic         frame_done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int     m_data [8];
  bit     m_valid [8];
  bit     m_ovr [8];
  int     m_ptr;
  bit     m_fd;

  demux1_8_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .datain(datain), .select(select), .valid_in(valid_in),
    .mode(mode), .sync(sync), .clear(clear), .rd_ack(rd_ack),
    .dataout_0(dout[0]), .dataout_1(dout[1]), .dataout_2(dout[2]), .dataout_3(dout[3]),
    .dataout_4(dout[4]), .dataout_5(dout[5]), .dataout_6(dout[6]), .dataout_7(dout[7]),
    .out_valid(out_valid), .overrun(overrun), .cur_ch(cur_ch), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a channel is a mailbox holding one word plus unread/overwritten flags.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_data[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
      end
      m_ptr = 0;
      m_fd  = 0;
    end else if (clear) begin
      for (int k = 0; k < 8; k++) begin
        m_valid[k] = 0; m_ovr[k] = 0;
      end
      m_ptr = 0;
      m_fd  = 0;
    end else begin
      int  t;
      bit  unread_lost;
      t = mode ? (sync ? 0 : m_ptr) : int'(select);
      unread_lost = valid_in && m_valid[t] && !rd_ack[t];
      for (int k = 0; k < 8; k++) begin
        if (rd_ack[k]) m_valid[k] = 0;
      end
      if (valid_in) begin
        m_data[t]  = int'(datain);
        m_valid[t] = 1;
        if (unread_lost) m_ovr[t] = 1;
      end
      m_fd = mode && valid_in && (t == 7);
      if (mode && valid_in) m_ptr = (t + 1) % 8;
      else if (mode && sync) m_ptr = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("model dataout_%0d", k), 32'(dout[k]), 32'(m_data[k]));
        chk($sformatf("model out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid[k]));
        chk($sformatf("model overrun[%0d]", k), 32'(overrun[k]), 32'(m_ovr[k]));
      end
      chk("model cur_ch", 32'(cur_ch), 32'(m_ptr));
      chk("model frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  // Apply one cycle of inputs, return 2ns after the edge with inputs idled.
  task automatic cyc(input bit v, input bit m, input int s, input bit sy, input bit cl,
                     input logic [7:0] ack, input int d);
    valid_in = v; mode = m; select = 3'(s); sync = sy; clear = cl; rd_ack = ack; datain = W'(d);
    @(posedge clk);
    #2;
    valid_in = 0; sync = 0; clear = 0; rd_ack = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 8; k++) chk($sformatf("%s dataout_%0d", tag, k), 32'(dout[k]), 0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " cur_ch"}, 32'(cur_ch), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #2 rst = 0;
    chk_en = 1;

    // Addressed write
    cyc(1, 0, 5, 0, 0, 8'h00, 'hA);
    chk("addr dataout_5", 32'(dout[5]), 32'hA);
    chk("addr out_valid", 32'(out_valid), 32'h20);
    chk("addr dataout_4", 32'(dout[4]), 0);
    chk("addr cur_ch", 32'(cur_ch), 0);
    cyc(0, 0, 0, 0, 0, 8'h01, 0);
    chk("ack idle ch0", 32'(out_valid), 32'h20);

    // Round-robin frame
    cyc(0, 1, 0, 0, 1, 8'h00, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 7 - k, 0, 0, 8'h00, k);
      chk($sformatf("rr frame_done w%0d", k), 32'(frame_done), (k == 7) ? 1 : 0);
    end
    for (int k = 0; k < 8; k++) chk($sformatf("rr dataout_%0d", k), 32'(dout[k]), k);
    chk("rr out_valid", 32'(out_valid), 32'hFF);
    chk("rr cur_ch wrap", 32'(cur_ch), 0);
    cyc(0, 1, 0, 0, 0, 8'h00, 0);
    chk("rr frame_done drop", 32'(frame_done), 0);

    // Overrun and ack race on channel 2
    cyc(0, 0, 0, 0, 1, 8'h00, 0);
    cyc(1, 0, 2, 0, 0, 8'h00, 1);
    cyc(1, 0, 2, 0, 0, 8'h00, 2);
    chk("ovr overrun", 32'(overrun), 32'h04);
    cyc(1, 0, 2, 0, 0, 8'h04, 3);
    chk("race out_valid", 32'(out_valid), 32'h04);
    chk("race overrun", 32'(overrun), 32'h04);
    chk("race dataout_2", 32'(dout[2]), 3);
    cyc(0, 0, 0, 0, 0, 8'h04, 0);
    chk("ack out_valid", 32'(out_valid), 0);
    chk("ack sticky overrun", 32'(overrun), 32'h04);

    // Sync behaviour
    cyc(0, 1, 0, 0, 1, 8'h00, 0);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 8'h00, k + 1);
    chk("sync pre cur_ch", 32'(cur_ch), 3);
    cyc(1, 1, 6, 1, 0, 8'h00, 9);
    chk("sync dataout_0", 32'(dout[0]), 9);
    chk("sync cur_ch", 32'(cur_ch), 1);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0, 8'h00, 4);
    chk("sync pre2 cur_ch", 32'(cur_ch), 5);
    cyc(0, 1, 0, 1, 0, 8'h00, 0);
    chk("sync alone cur_ch", 32'(cur_ch), 0);
    cyc(1, 1, 0, 0, 0, 8'h00, 'hB);
    cyc(1, 0, 6, 1, 0, 8'h00, 'hD);
    chk("mode0 sync ignored cur_ch", 32'(cur_ch), 1);
    chk("mode0 dataout_6", 32'(dout[6]), 32'hD);
    cyc(1, 1, 5, 0, 0, 8'h00, 'hE);
    chk("mode switch dataout_1", 32'(dout[1]), 32'hE);
    chk("mode switch cur_ch", 32'(cur_ch), 2);

    // Clear priority over a simultaneous write
    cyc(1, 0, 4, 0, 0, 8'h00, 5);
    cyc(1, 0, 4, 0, 0, 8'h00, 6);
    chk("pre clear overrun4", 32'(overrun[4]), 1);
    cyc(1, 0, 4, 0, 1, 8'h00, 'hF);
    chk("clear out_valid", 32'(out_valid), 0);
    chk("clear overrun", 32'(overrun), 0);
    chk("clear cur_ch", 32'(cur_ch), 0);
    chk("clear dataout_4", 32'(dout[4]), 6);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 8'h00, k + 1);
    #1 rst = 1;
    #1;
    chk_all_zero("async rst");
    valid_in = 1; mode = 1; datain = 4'h7; rd_ack = 8'hFF;
    @(posedge clk);
    #2;
    chk_all_zero("rst held");
    rst = 0;
    cyc(1, 1, 3, 0, 0, 8'h00, 'hC);
    chk("post rst dataout_0", 32'(dout[0]), 32'hC);
    chk("post rst out_valid", 32'(out_valid), 32'h01);
    chk("post rst cur_ch", 32'(cur_ch), 1);
    cyc(0, 1, 0, 0, 0, 8'h00, 0);

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux1_8_seq.md
DEMUX1_8_SEQ -- requirements
Module: demux1_8_seq

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per channel.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 datain  input  WIDTH  data word to be routed.
REQ-005 select  input  3  target channel in addressed mode.
REQ-006 valid_in  input  1  datain is to be written this cycle.
REQ-007 mode  input  1  0 = addressed (select), 1 = round-robin (internal pointer).
REQ-008 sync  input  1  round-robin restart, forces target channel 0 and pointer restart.
REQ-009 clear  input  1  synchronous clear of flags and pointer.
REQ-010 rd_ack  input  8  bit k: consumer has taken dataout_k.
REQ-011 dataout_0 .. dataout_7  output  WIDTH each  per-channel held data.
REQ-012 out_valid  output  8  bit k: dataout_k holds unread data.
REQ-013 overrun  output  8  bit k: sticky, unread data on channel k was overwritten.
REQ-014 cur_ch  output  3  current round-robin pointer.
REQ-015 frame_done  output  1  one-cycle pulse on completion of a round-robin frame.

Function
REQ-016 An accepted write is valid_in=1 with clear=0 at a rising edge; target = select in mode 0, = pointer in mode 1, = 0 whenever mode=1 and sync=1.
REQ-017 Latency one cycle: dataout_target and out_valid[target] update at the accepting edge, visible immediately after it.
REQ-018 Non-targeted dataout_k and their out_valid/overrun bits shall hold, except for rd_ack effects.
REQ-019 rd_ack[k]=1 shall clear out_valid[k] at the edge; rd_ack on a channel with out_valid=0 has no effect.
REQ-020 Write and rd_ack[k] on the same channel in the same cycle: write wins, out_valid[k] stays 1, overrun[k] unchanged.
REQ-021 Write to channel k with out_valid[k]=1 and rd_ack[k]=0: data overwritten, out_valid[k]=1, overrun[k] set.
REQ-022 overrun bits are sticky; cleared only by clear or rst.
REQ-023 Mode 1, accepted write: pointer = target+1 mod 8 (wrap 7->0); sync with no write: pointer = 0.
REQ-024 Mode 0: pointer holds; sync ignored; select ignored in mode 1.
REQ-025 frame_done shall be 1 for exactly the cycle following an accepted mode-1 write to channel 7, else 0.
REQ-026 clear=1 shall, at the edge: out_valid=0, overrun=0, pointer=0, frame_done=0; dataout_k hold; any simultaneous write is discarded.
REQ-027 Mode change takes effect the same cycle; pointer value is preserved across mode changes.
REQ-028 cur_ch shall equal the registered pointer at all times.

Reset
REQ-029 rst=1 shall immediately, without clock: all dataout_k=0, out_valid=0, overrun=0, pointer=0, cur_ch=0, frame_done=0.
REQ-030 Reset asserted mid-frame shall discard the frame; first write after release in mode 1 targets channel 0.
REQ-031 No write, ack or pointer change shall occur on an edge where rst=1.

Verification
REQ-032 Addressed: mode=0, write datain=4'hA select=5 -> next cycle dataout_5=A, out_valid=8'h20, others unchanged at 0.
REQ-033 Round-robin: mode=1, 8 consecutive writes 0..7 -> dataout_k=k, out_valid=8'hFF, cur_ch wraps to 0, frame_done high one cycle after the 8th write.
REQ-034 Overrun/ack race: channel 2 valid; write again with rd_ack[2]=0 -> overrun=8'h04; write with rd_ack[2]=1 simultaneously -> out_valid[2]=1, overrun unchanged.
REQ-035 Sync: mode=1, pointer=3, sync+write datain=4'h9 -> dataout_0=9, cur_ch=1; sync alone at pointer 5 -> cur_ch=0.
REQ-036 Clear priority: clear+write to channel 4 with flags set -> out_valid=0, overrun=0, cur_ch=0, dataout_4 unchanged.
REQ-037 Async reset: assert rst between edges mid-frame -> all outputs 0 before next edge; after release first mode-1 write lands on channel 0.
